pipeline_stage_hs: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, stall, flush-to-bubble and saturating stall/bubble counters. It is the generic successor of the fixed ID/EX register and sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The control and payload buses are concatenated by the instantiating stage, so one block serves every boundary.

---
 rtl/pipeline_stage_hs.sv | 147 ++++++++++++++
 tb/tb_pipeline_stage_hs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and saturating stall/bubble counters.
// Optional skid entry with registered up_ready when PIPE_SKID_EN is defined.
module pipeline_stage_hs #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              r_main_vld_p1;
  logic [CTRL_W-1:0] r_main_ctrl_p1;
  logic [DATA_W-1:0] r_main_data_p1;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_xfer_in;
  logic              w_xfer_out;

  assign w_xfer_in  = up_valid & up_ready;
  assign w_xfer_out = r_main_vld_p1 & dn_ready;

`ifdef PIPE_SKID_EN
  logic              r_skid_vld_p1;
  logic [CTRL_W-1:0] r_skid_ctrl_p1;
  logic [DATA_W-1:0] r_skid_data_p1;
  logic              w_skid_load;

  // up_ready depends only on state, breaking the dn_ready -> up_ready path
  assign up_ready    = ~r_skid_vld_p1;
  assign w_skid_load = w_xfer_in & r_main_vld_p1 & ~dn_ready & ~flush;

  // p1 stage: main entry control; skid drains into main on every transfer out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_vld_p1  <= 1'b0;
      r_main_ctrl_p1 <= '0;
      r_skid_vld_p1  <= 1'b0;
    end else if (flush) begin
      r_main_vld_p1  <= 1'b0;
      r_main_ctrl_p1 <= '0;
      r_skid_vld_p1  <= 1'b0;
    end else if (w_xfer_out) begin
      if (r_skid_vld_p1) begin
        r_main_ctrl_p1 <= r_skid_ctrl_p1;
        r_skid_vld_p1  <= 1'b0;
      end else if (w_xfer_in) begin
        r_main_ctrl_p1 <= up_ctrl;
      end else begin
        r_main_vld_p1  <= 1'b0;
        r_main_ctrl_p1 <= '0;
      end
    end else if (w_xfer_in) begin
      if (r_main_vld_p1) begin
        r_skid_vld_p1 <= 1'b1;
      end else begin
        r_main_vld_p1  <= 1'b1;
        r_main_ctrl_p1 <= up_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data_p1 <= '0;
    end else if (!flush) begin
      if (w_xfer_out) begin
        if (r_skid_vld_p1) begin
          r_main_data_p1 <= r_skid_data_p1;
        end else if (w_xfer_in) begin
          r_main_data_p1 <= up_data;
        end
      end else if (w_xfer_in && !r_main_vld_p1) begin
        r_main_data_p1 <= up_data;
      end
    end
  end

  // Skid payload needs no reset: it is only read while r_skid_vld_p1 is set
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_ctrl_p1 <= up_ctrl;
      r_skid_data_p1 <= up_data;
    end
  end
`else
  assign up_ready = ~r_main_vld_p1 | dn_ready;

  // p1 stage: single entry; a word leaving without a replacement becomes a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_vld_p1  <= 1'b0;
      r_main_ctrl_p1 <= '0;
    end else if (flush) begin
      r_main_vld_p1  <= 1'b0;
      r_main_ctrl_p1 <= '0;
    end else if (w_xfer_in) begin
      r_main_vld_p1  <= 1'b1;
      r_main_ctrl_p1 <= up_ctrl;
    end else if (w_xfer_out) begin
      r_main_vld_p1  <= 1'b0;
      r_main_ctrl_p1 <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data_p1 <= '0;
    end else if (!flush && w_xfer_in) begin
      r_main_data_p1 <= up_data;
    end
  end
`endif

  // Counters observe the registered state ahead of the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_main_vld_p1 && !dn_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (!r_main_vld_p1)             r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign dn_valid   = r_main_vld_p1;
  assign dn_ctrl    = r_main_ctrl_p1;
  assign dn_data    = r_main_data_p1;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipeline_stage_hs.sv
// Self-checking bench for pipeline_stage_hs: vector table, scoreboard, and hand-written corner sequences.
module tb_pipeline_stage_hs;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic [7:0]   up_ctrl = '0;
  logic [127:0] up_data = '0;
  logic         dn_valid;
  logic         dn_ready = 1'b0;
  logic [7:0]   dn_ctrl;
  logic [127:0] dn_data;
  logic         flush = 1'b0;
  logic [15:0]  stall_cnt;
  logic [15:0]  bubble_cnt;

  logic         up_ready4;
  logic         dn_valid4;
  logic [7:0]   dn_ctrl4;
  logic [15:0]  dn_data4;
  logic [3:0]   stall_cnt4;
  logic [3:0]   bubble_cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_stage_hs u_dut (
    .clk(clk), .reset(reset), .up_valid(up_valid), .up_ready(up_ready),
    .up_ctrl(up_ctrl), .up_data(up_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .dn_ctrl(dn_ctrl), .dn_data(dn_data), .flush(flush),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipeline_stage_hs #(.CTRL_W(8), .DATA_W(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .up_valid(up_valid), .up_ready(up_ready4),
    .up_ctrl(up_ctrl), .up_data(up_data[15:0]), .dn_valid(dn_valid4), .dn_ready(dn_ready),
    .dn_ctrl(dn_ctrl4), .dn_data(dn_data4), .flush(flush),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic uv, input logic [7:0] uc, input logic [127:0] ud,
                       input logic dr, input logic fl);
    up_valid = uv;
    up_ctrl  = uc;
    up_data  = ud;
    dn_ready = dr;
    flush    = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Scoreboard: words pushed on accept, popped when downstream consumes
  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
  } word_t;
  word_t sb_q[$];

  always @(negedge clk) begin
    word_t w;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (!dn_valid) chk("bubble_inv", 128'(dn_ctrl), 128'h0);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (dn_valid && dn_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_word", 128'(dn_ctrl), 128'h0);
            chk("sb_unexpected", 128'd1, 128'd0);
          end else begin
            w = sb_q.pop_front();
            chk("sb_ctrl", 128'(dn_ctrl), 128'(w.c));
            chk("sb_data", dn_data, w.d);
          end
        end
        if (up_valid && up_ready) sb_q.push_back({up_ctrl, up_data});
      end
    end
  end

  typedef struct {
    logic         uv;
    logic [7:0]   uc;
    logic [127:0] ud;
    logic         dr;
    logic         fl;
    logic         ev;
    logic [7:0]   ec;
    logic [127:0] ed;
    logic         eur;
    logic [15:0]  es;
    logic [15:0]  eb;
  } vec_t;

  function automatic vec_t mk(input logic uv, input logic [7:0] uc, input logic [127:0] ud,
                              input logic dr, input logic fl, input logic ev,
                              input logic [7:0] ec, input logic [127:0] ed, input logic eur,
                              input logic [15:0] es, input logic [15:0] eb);
    vec_t v;
    v.uv = uv; v.uc = uc; v.ud = ud; v.dr = dr; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ed = ed; v.eur = eur; v.es = es; v.eb = eb;
    return v;
  endfunction

  vec_t tbl [18];
  logic eur_row;

  initial begin
    // Expected values describe the state just after each row's clock edge
    tbl[0]  = mk(1, 8'h01, 128'h101,  1, 0,  1, 8'h01, 128'h101,  1, 0, 1);
    tbl[1]  = mk(1, 8'h02, 128'h102,  1, 0,  1, 8'h02, 128'h102,  1, 0, 1);
    tbl[2]  = mk(1, 8'h03, 128'h103,  1, 0,  1, 8'h03, 128'h103,  1, 0, 1);
    tbl[3]  = mk(1, 8'h04, 128'h104,  1, 0,  1, 8'h04, 128'h104,  1, 0, 1);
    tbl[4]  = mk(1, 8'h05, 128'h105,  1, 0,  1, 8'h05, 128'h105,  1, 0, 1);
    tbl[5]  = mk(0, 8'h00, 128'h0,    1, 0,  0, 8'h00, 128'h105,  1, 0, 1);
    tbl[6]  = mk(0, 8'h00, 128'h0,    1, 0,  0, 8'h00, 128'h105,  1, 0, 2);
    tbl[7]  = mk(0, 8'h00, 128'h0,    1, 0,  0, 8'h00, 128'h105,  1, 0, 3);
    tbl[8]  = mk(0, 8'h00, 128'h0,    1, 0,  0, 8'h00, 128'h105,  1, 0, 4);
    tbl[9]  = mk(1, 8'hA5, 128'h1234, 0, 0,  1, 8'hA5, 128'h1234, 0, 0, 5);
    tbl[10] = mk(0, 8'h00, 128'h0,    0, 0,  1, 8'hA5, 128'h1234, 0, 1, 5);
    tbl[11] = mk(0, 8'h00, 128'h0,    0, 0,  1, 8'hA5, 128'h1234, 0, 2, 5);
    tbl[12] = mk(0, 8'h00, 128'h0,    0, 0,  1, 8'hA5, 128'h1234, 0, 3, 5);
    tbl[13] = mk(0, 8'h00, 128'h0,    0, 0,  1, 8'hA5, 128'h1234, 0, 4, 5);
    tbl[14] = mk(0, 8'h00, 128'h0,    1, 0,  0, 8'h00, 128'h1234, 1, 4, 5);
    tbl[15] = mk(1, 8'h3C, 128'h3C3C, 0, 0,  1, 8'h3C, 128'h3C3C, 0, 4, 6);
    tbl[16] = mk(1, 8'h7E, 128'h7E7E, 0, 1,  0, 8'h00, 128'h3C3C, 1, 5, 6);
    tbl[17] = mk(0, 8'h00, 128'h0,    1, 0,  0, 8'h00, 128'h3C3C, 1, 5, 7);

    do_reset();
    chk("rst_dn_valid", 128'(dn_valid), 128'd0);
    chk("rst_dn_ctrl", 128'(dn_ctrl), 128'h0);
    chk("rst_dn_data", dn_data, 128'h0);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("rst_bubble_cnt", 128'(bubble_cnt), 128'd0);
    chk("rst_up_ready", 128'(up_ready), 128'd1);

    foreach (tbl[i]) begin
      drive(tbl[i].uv, tbl[i].uc, tbl[i].ud, tbl[i].dr, tbl[i].fl);
      step();
`ifdef PIPE_SKID_EN
      eur_row = 1'b1;
`else
      eur_row = tbl[i].eur;
`endif
      chk($sformatf("row%0d_dn_valid", i), 128'(dn_valid), 128'(tbl[i].ev));
      chk($sformatf("row%0d_dn_ctrl", i), 128'(dn_ctrl), 128'(tbl[i].ec));
      chk($sformatf("row%0d_dn_data", i), dn_data, tbl[i].ed);
      chk($sformatf("row%0d_up_ready", i), 128'(up_ready), 128'(eur_row));
      chk($sformatf("row%0d_stall_cnt", i), 128'(stall_cnt), 128'(tbl[i].es));
      chk($sformatf("row%0d_bubble_cnt", i), 128'(bubble_cnt), 128'(tbl[i].eb));
    end

    // Long stall: the 4-bit counters saturate at 15, the 16-bit ones keep counting
    do_reset();
    drive(1'b1, 8'h55, 128'h55, 1'b0, 1'b0);
    step();
    chk("sat_dn_data4", 128'(dn_data4), 128'h55);
    drive(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat_stall_cnt4", 128'(stall_cnt4), 128'd15);
    chk("sat_stall_cnt", 128'(stall_cnt), 128'd20);
    repeat (2) step();
    chk("sat_stall_cnt4_hold", 128'(stall_cnt4), 128'd15);
    chk("sat_stall_cnt_22", 128'(stall_cnt), 128'd22);
    chk("sat_bubble_cnt4", 128'(bubble_cnt4), 128'd1);
    chk("sat_dn_ctrl", 128'(dn_ctrl), 128'h55);
    drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
    step();
    chk("sat_drained", 128'(dn_valid), 128'd0);
    step();

`ifdef PIPE_SKID_EN
    // Two words into a stalled stage: second lands in skid, up_ready falls, order kept
    do_reset();
    drive(1'b1, 8'h11, 128'h11, 1'b0, 1'b0);
    step();
    chk("skid_first_ctrl", 128'(dn_ctrl), 128'h11);
    chk("skid_first_ur", 128'(up_ready), 128'd1);
    drive(1'b1, 8'h22, 128'h22, 1'b0, 1'b0);
    step();
    chk("skid_full_ur", 128'(up_ready), 128'd0);
    chk("skid_full_ctrl", 128'(dn_ctrl), 128'h11);
    drive(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
    step();
    chk("skid_hold_ur", 128'(up_ready), 128'd0);
    drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
    step();
    chk("skid_second_ctrl", 128'(dn_ctrl), 128'h22);
    chk("skid_second_data", dn_data, 128'h22);
    chk("skid_free_ur", 128'(up_ready), 128'd1);
    step();
    chk("skid_drained", 128'(dn_valid), 128'd0);
    drive(1'b1, 8'h33, 128'h33, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h44, 128'h44, 1'b0, 1'b0);
    step();
    chk("skid_pre_flush_ur", 128'(up_ready), 128'd0);
    drive(1'b0, 8'h00, 128'h0, 1'b0, 1'b1);
    step();
    chk("skid_flush_valid", 128'(dn_valid), 128'd0);
    chk("skid_flush_ur", 128'(up_ready), 128'd1);
    drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
    step();
    chk("skid_flush_both", 128'(dn_valid), 128'd0);
    step();
`else
    // Base mode: up_ready follows dn_ready combinationally while a word is held
    do_reset();
    drive(1'b1, 8'h66, 128'h66, 1'b0, 1'b0);
    step();
    up_valid = 1'b0;
    #1;
    chk("comb_ur_low", 128'(up_ready), 128'd0);
    dn_ready = 1'b1;
    #1;
    chk("comb_ur_high", 128'(up_ready), 128'd1);
    step();
    chk("comb_drained", 128'(dn_valid), 128'd0);
    step();
`endif

    // Reset mid-stall discards the held word
    drive(1'b1, 8'h99, 128'h99, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    flush = 1'b1;
    up_valid = 1'b0;
    step();
    reset = 1'b0;
    flush = 1'b0;
    chk("rst_stall_valid", 128'(dn_valid), 128'd0);
    chk("rst_stall_data", dn_data, 128'h0);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    dn_ready = 1'b1;
    repeat (2) step();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
